// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_cla_adder
// Brief    : Two-stage pipelined carry-lookahead adder/subtractor with
//            valid/ready handshakes. 4-bit groups form generate/propagate
//            terms in stage 1; stage 2 runs a flattened group lookahead,
//            in-group bit lookahead and the sum XOR.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_cla_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int GROUPS = WIDTH / 4;

  // Stage 1 registers: operands with B already conditioned for subtraction
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_c0;

  // Stage 1 combinational generate/propagate terms
  logic [WIDTH-1:0]  g1;
  logic [WIDTH-1:0]  p1;
  logic [GROUPS-1:0] gg1;
  logic [GROUPS-1:0] gp1;

  // Stage 2 registers: bit and group terms plus the initial carry
  logic              s2_valid;
  logic [WIDTH-1:0]  s2_p;
  logic [WIDTH-1:0]  s2_g;
  logic [GROUPS-1:0] s2_gg;
  logic [GROUPS-1:0] s2_gp;
  logic              s2_c0;

  // Stage 2 carries
  logic [GROUPS:0]   group_c;
  logic [WIDTH-1:0]  bit_c;

  logic accept;
  logic adv2;

  // Stage 2 advances when it is empty or its beat is being consumed
  assign adv2      = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || adv2;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  // Stage 1 capture: subtraction becomes A + ~B + 1, cin is then ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c0    <= 1'b0;
    end else begin
      if (accept) begin
        s1_a  <= a;
        s1_b  <= sub ? ~b : b;
        s1_c0 <= sub | cin;
      end
      if (accept) begin
        s1_valid <= 1'b1;
      end else if (adv2) begin
        s1_valid <= 1'b0;
      end
    end
  end

  assign g1 = s1_a & s1_b;
  assign p1 = s1_a ^ s1_b;

  for (genvar gi = 0; gi < GROUPS; gi++) begin : g_group
    localparam int B = 4 * gi;
    assign gg1[gi] = g1[B+3]
                   | (p1[B+3] & g1[B+2])
                   | (p1[B+3] & p1[B+2] & g1[B+1])
                   | (p1[B+3] & p1[B+2] & p1[B+1] & g1[B]);
    assign gp1[gi] = &p1[B+3:B];
  end

  // Stage 2 capture; holds its beat while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_p     <= '0;
      s2_g     <= '0;
      s2_gg    <= '0;
      s2_gp    <= '0;
      s2_c0    <= 1'b0;
    end else begin
      if (adv2) begin
        s2_p  <= p1;
        s2_g  <= g1;
        s2_gg <= gg1;
        s2_gp <= gp1;
        s2_c0 <= s1_c0;
      end
      if (adv2) begin
        s2_valid <= 1'b1;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // Group carries as a flat sum of products over all lower groups
  always_comb begin
    logic term;
    logic carry;
    term       = 1'b0;
    carry      = 1'b0;
    group_c    = '0;
    group_c[0] = s2_c0;
    for (int k = 0; k < GROUPS; k++) begin
      term = s2_c0;
      for (int m = 0; m <= k; m++) term = term & s2_gp[m];
      carry = term;
      for (int j = 0; j <= k; j++) begin
        term = s2_gg[j];
        for (int m = j + 1; m <= k; m++) term = term & s2_gp[m];
        carry = carry | term;
      end
      group_c[k+1] = carry;
    end
  end

  // Bit carries: 4-bit lookahead inside each group seeded by its group carry
  always_comb begin
    logic term;
    logic carry;
    term  = 1'b0;
    carry = 1'b0;
    bit_c = '0;
    for (int k = 0; k < GROUPS; k++) begin
      for (int i = 0; i < 4; i++) begin
        carry = group_c[k];
        for (int m = 0; m < i; m++) carry = carry & s2_p[4*k+m];
        for (int j = 0; j < i; j++) begin
          term = s2_g[4*k+j];
          for (int m = j + 1; m < i; m++) term = term & s2_p[4*k+m];
          carry = carry | term;
        end
        bit_c[4*k+i] = carry;
      end
    end
  end

  assign sum  = s2_p ^ bit_c;
  assign cout = group_c[GROUPS];
  assign ovf  = bit_c[WIDTH-1] ^ group_c[GROUPS];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_cla_adder
// Brief    : Scoreboard bench for pipelined_cla_adder at WIDTH 4, 16 and 32,
//            all three instances sharing one handshake stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_cla_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;

  logic        in_ready4, in_ready16, in_ready32;
  logic        out_valid4, out_valid16, out_valid32;
  logic [3:0]  sum4;
  logic [15:0] sum16;
  logic [31:0] sum32;
  logic        cout4, cout16, cout32;
  logic        ovf4, ovf16, ovf32;

  int errors = 0;
  int checks = 0;

  // Entries are {ovf, cout, sum zero-extended to 32 bits}
  logic [33:0] q4[$];
  logic [33:0] q16[$];
  logic [33:0] q32[$];
  logic [33:0] obs4, obs16, obs32;
  logic [33:0] exp_v;
  logic        fire_in, fire_out;

  pipelined_cla_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a_in[3:0]), .b(b_in[3:0]), .cin(cin), .sub(sub),
    .out_valid(out_valid4), .out_ready(out_ready),
    .sum(sum4), .cout(cout4), .ovf(ovf4));

  pipelined_cla_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .a(a_in[15:0]), .b(b_in[15:0]), .cin(cin), .sub(sub),
    .out_valid(out_valid16), .out_ready(out_ready),
    .sum(sum16), .cout(cout16), .ovf(ovf16));

  pipelined_cla_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .a(a_in), .b(b_in), .cin(cin), .sub(sub),
    .out_valid(out_valid32), .out_ready(out_ready),
    .sum(sum32), .cout(cout32), .ovf(ovf32));

  always #5 clk = ~clk;

  // Reference: plain wide integer addition, then masked to the width
  function automatic logic [33:0] model(input int w, input logic [31:0] av,
                                        input logic [31:0] bv, input logic cv,
                                        input logic sv);
    logic [31:0] mask, aa, bb, s;
    logic [34:0] full;
    logic        c, co, ov;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    aa   = av & mask;
    bb   = (sv ? ~bv : bv) & mask;
    c    = sv ? 1'b1 : cv;
    full = {3'b0, aa} + {3'b0, bb} + {34'b0, c};
    s    = full[31:0] & mask;
    co   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {ov, co, s};
  endfunction

  // One clock: observe at negedge, record transfers, push expectations
  task automatic drive_cycle();
    @(negedge clk);
    obs4     = {ovf4, cout4, 28'd0, sum4};
    obs16    = {ovf16, cout16, 16'd0, sum16};
    obs32    = {ovf32, cout32, sum32};
    fire_in  = in_valid && in_ready16;
    fire_out = out_valid16 && out_ready;
    if (fire_in) begin
      q4.push_back(model(4, a_in, b_in, cin, sub));
      q16.push_back(model(16, a_in, b_in, cin, sub));
      q32.push_back(model(32, a_in, b_in, cin, sub));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (in_ready16 !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got=%b exp=1", in_ready16); end
    checks++; if (out_valid16 !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got=%b exp=0", out_valid16); end
    checks++; if (sum16 !== 16'h0) begin errors++; $display("FAIL rst_sum: got=%h exp=0000", sum16); end
    checks++; if (cout16 !== 1'b0) begin errors++; $display("FAIL rst_cout: got=%b exp=0", cout16); end
    checks++; if (ovf16 !== 1'b0) begin errors++; $display("FAIL rst_ovf: got=%b exp=0", ovf16); end
    rst = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; a_in = 32'd5; b_in = 32'd7; cin = 1'b0; sub = 1'b0;
    drive_cycle();
    a_in = 32'd9; b_in = 32'd3;
    drive_cycle();
    in_valid = 1'b0;
    checks++; if (out_valid16 !== 1'b1) begin errors++; $display("FAIL inflight_valid: got=%b exp=1", out_valid16); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid16 !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got=%b exp=0", out_valid16); end
    checks++; if (sum16 !== 16'h0) begin errors++; $display("FAIL midrst_sum: got=%h exp=0000", sum16); end
    checks++; if (in_ready16 !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got=%b exp=1", in_ready16); end
    q4.delete(); q16.delete(); q32.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_cycle();
      checks++; if (out_valid16 !== 1'b0) begin errors++; $display("FAIL stale_beat cycle %0d: got out_valid=%b exp=0", i, out_valid16); end
    end
  endtask

  task automatic test_vector(input string name, input logic [15:0] av,
                             input logic [15:0] bv, input logic cv, input logic sv,
                             input logic [15:0] es, input logic ec, input logic eo);
    int  lat;
    logic got;
    out_ready = 1'b1;
    in_valid = 1'b1; a_in = {16'h0, av}; b_in = {16'h0, bv}; cin = cv; sub = sv;
    drive_cycle();
    in_valid = 1'b0;
    checks++; if (fire_in !== 1'b1) begin errors++; $display("FAIL %s_accept: got=%b exp=1", name, fire_in); end
    lat = 0; got = 1'b0;
    while (!got && lat < 10) begin
      drive_cycle();
      lat++;
      if (fire_out) got = 1'b1;
    end
    checks++; if (!got || lat != 2) begin errors++; $display("FAIL %s_latency: got=%0d exp=2", name, got ? lat : -1); end
    if (got) begin
      checks++;
      if (obs16 !== {eo, ec, 16'd0, es}) begin
        errors++;
        $display("FAIL %s: got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                 name, obs16[15:0], obs16[32], obs16[33], es, ec, eo);
      end
      exp_v = q4.pop_front();
      checks++; if (obs4 !== exp_v) begin errors++; $display("FAIL %s_w4: got=%h exp=%h", name, obs4, exp_v); end
      exp_v = q32.pop_front();
      checks++; if (obs32 !== exp_v) begin errors++; $display("FAIL %s_w32: got=%h exp=%h", name, obs32, exp_v); end
      exp_v = q16.pop_front();
    end
  endtask

  task automatic test_backpressure();
    int          sent, recv;
    logic        saw_stall, held;
    logic [33:0] prev_obs;
    sent = 0; recv = 0; saw_stall = 1'b0; held = 1'b0; prev_obs = '0;
    for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
      in_valid  = (sent < 5);
      a_in      = 32'h1111_1111 * (sent + 1);
      b_in      = 32'h0F0F_0F0F + sent;
      cin       = sent[0];
      sub       = (sent == 3);
      out_ready = !(cyc >= 2 && cyc < 6);
      drive_cycle();
      if (!in_ready16) saw_stall = 1'b1;
      if (held) begin
        checks++;
        if (out_valid16 !== 1'b1 || obs16 !== prev_obs) begin
          errors++;
          $display("FAIL bp_stable: got valid=%b out=%h exp valid=1 out=%h", out_valid16, obs16, prev_obs);
        end
      end
      held     = out_valid16 && !out_ready;
      prev_obs = obs16;
      if (fire_in) sent++;
      if (fire_out) begin
        recv++;
        exp_v = q16.pop_front();
        checks++; if (obs16 !== exp_v) begin errors++; $display("FAIL bp_beat%0d: got=%h exp=%h", recv, obs16, exp_v); end
        exp_v = q4.pop_front();
        checks++; if (obs4 !== exp_v) begin errors++; $display("FAIL bp_w4_beat%0d: got=%h exp=%h", recv, obs4, exp_v); end
        exp_v = q32.pop_front();
        checks++; if (obs32 !== exp_v) begin errors++; $display("FAIL bp_w32_beat%0d: got=%h exp=%h", recv, obs32, exp_v); end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (recv != 5) begin errors++; $display("FAIL bp_count: got=%0d exp=5", recv); end
    checks++; if (saw_stall !== 1'b1) begin errors++; $display("FAIL bp_in_ready_fall: got=%b exp=1", saw_stall); end
    checks++; if (q16.size() != 0) begin errors++; $display("FAIL bp_leftover: got=%0d exp=0", q16.size()); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a_in      = $urandom;
      b_in      = $urandom;
      cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      drive_cycle();
      checks++;
      if ({in_ready4, in_ready32, out_valid4, out_valid32} !==
          {in_ready16, in_ready16, out_valid16, out_valid16}) begin
        errors++;
        $display("FAIL rand_handshake: got=%b%b%b%b exp=%b%b%b%b", in_ready4, in_ready32,
                 out_valid4, out_valid32, in_ready16, in_ready16, out_valid16, out_valid16);
      end
      if (fire_out) begin
        checks++;
        if (q16.size() == 0) begin
          errors++; $display("FAIL rand_spurious: got=1 output exp=0 outputs");
        end else begin
          exp_v = q16.pop_front();
          if (obs16 !== exp_v) begin errors++; $display("FAIL rand_w16: got=%h exp=%h", obs16, exp_v); end
          exp_v = q4.pop_front();
          checks++; if (obs4 !== exp_v) begin errors++; $display("FAIL rand_w4: got=%h exp=%h", obs4, exp_v); end
          exp_v = q32.pop_front();
          checks++; if (obs32 !== exp_v) begin errors++; $display("FAIL rand_w32: got=%h exp=%h", obs32, exp_v); end
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && q16.size() != 0; i++) begin
      drive_cycle();
      if (fire_out) begin
        exp_v = q16.pop_front();
        checks++; if (obs16 !== exp_v) begin errors++; $display("FAIL drain_w16: got=%h exp=%h", obs16, exp_v); end
        exp_v = q4.pop_front();
        checks++; if (obs4 !== exp_v) begin errors++; $display("FAIL drain_w4: got=%h exp=%h", obs4, exp_v); end
        exp_v = q32.pop_front();
        checks++; if (obs32 !== exp_v) begin errors++; $display("FAIL drain_w32: got=%h exp=%h", obs32, exp_v); end
      end
    end
    checks++;
    if (q4.size() != 0 || q16.size() != 0 || q32.size() != 0) begin
      errors++;
      $display("FAIL drain_empty: got=%0d/%0d/%0d pending exp=0", q4.size(), q16.size(), q32.size());
    end
    drive_cycle();
    checks++; if (out_valid16 !== 1'b0) begin errors++; $display("FAIL drain_idle: got=%b exp=0", out_valid16); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_vector("carry_prop", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    test_vector("ovf_add",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    test_vector("ovf_sub",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    test_vector("sub_borrow", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    test_backpressure();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
